// File: rtl/addr_burst_if.sv
// addr_burst_if
//   Groups the bus-side signals of the burst address register.
//   master: drives the command inputs (en, dIn, start, burst_len, step, abort)
//           and observes the status outputs.
//   slave : the address register itself.
//   Signals:
//     en        load strobe; dIn is captured into dOut (IDLE only)
//     dIn       address from the bus
//     start     begin a burst from the current dOut
//     burst_len number of increments in the burst
//     step      one-cycle advance pulse during a burst
//     abort     cancel a burst in progress
//     dOut      current address to RAM
//     busy      high while a burst is running
//     done      one-cycle pulse when a burst completes
//     wrapped   sticky flag: an increment wrapped max->0
//     err       sticky flag: overflow with wrapping disabled
interface addr_burst_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
);
  logic              en;
  logic [ADDR_W-1:0] dIn;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              step;
  logic              abort;
  logic [ADDR_W-1:0] dOut;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic              err;

  modport master (
    output en, dIn, start, burst_len, step, abort,
    input  dOut, busy, done, wrapped, err
  );

  modport slave (
    input  en, dIn, start, burst_len, step, abort,
    output dOut, busy, done, wrapped, err
  );
endinterface

// File: rtl/addr_burst_reg.sv
// addr_burst_reg
//   Memory address register for the 4-bit computer datapath. Loads the RAM
//   address from the bus, or runs a counted burst that advances the address
//   once per step pulse. All outputs are registered.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   addr_burst_if.slave (en, dIn, start, burst_len, step, abort in;
//           dOut, busy, done, wrapped, err out)
//   Parameters:
//     ADDR_W   address width; the address wraps modulo 2**ADDR_W
//     LEN_W    burst-length counter width
//     WRAP_EN  1: stepping past max wraps to 0; 0: it ends the burst with err
module addr_burst_reg #(
  parameter int ADDR_W  = 4,
  parameter int LEN_W   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  addr_burst_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              wrapped_q, wrapped_d;
  logic              err_q, err_d;
  logic              busy_q, done_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers; busy/done are registered decodes of the
  // next state so they line up exactly with BURST/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
      busy_q    <= (state_d == BURST);
      done_q    <= (state_d == DONE);
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        // A load wins over a start in the same cycle.
        if (bus.en) begin
          addr_d    = bus.dIn;
          wrapped_d = 1'b0;
          err_d     = 1'b0;
        end else if (bus.start) begin
          if (bus.burst_len != '0) begin
            rem_d     = bus.burst_len;
            wrapped_d = 1'b0;
            err_d     = 1'b0;
            state_d   = BURST;
          end else begin
            // Zero-length burst: report completion without moving dOut.
            state_d = DONE;
          end
        end
      end

      BURST: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.step) begin
          if (addr_q != ADDR_MAX) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) state_d = DONE;
          end else if (WRAP_EN) begin
            addr_d    = '0;
            wrapped_d = 1'b1;
            rem_d     = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) state_d = DONE;
          end else begin
            // Overflow without wrapping truncates the burst; dOut stays at max.
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dOut    = addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wrapped = wrapped_q;
  assign bus.err     = err_q;

endmodule
